text_cursor_ctrl: RTL

Command-driven writer for the 100×75 character map RAM that feeds the text overlay pixel generator. It accepts put-character, set-position, newline and clear commands from the game/CPU side over a valid/ready handshake. It maintains a text cursor and drives the character RAM write port: linear cell address, ASCII byte and write strobe. It sits between the command source and the character RAM write side; the read side stays owned by the pixel generator.

---
 rtl/text_cursor_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/text_cursor_ctrl.sv
// Command-driven writer for the text overlay character RAM: cursor tracking plus PUTC/SETPOS/NEWLINE/CLEAR.
// Optional TEXT_CTRL_CLEAR_EN compiles in the full-screen clear sequence; otherwise CLEAR only homes the cursor.
module text_cursor_ctrl #(
  parameter int COLS   = 100,
  parameter int ROWS   = 75,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [13:0]       cmd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic [6:0]        cursor_col,
  output logic [6:0]        cursor_row
);

  typedef enum logic [1:0] {
    OP_PUTC    = 2'b00,
    OP_SETPOS  = 2'b01,
    OP_NEWLINE = 2'b10,
    OP_CLEAR   = 2'b11
  } op_e;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [6:0]        col_q, col_d;
  logic [6:0]        row_q, row_d;
  logic [ADDR_W-1:0] cur_addr;
  logic              accept;

`ifdef TEXT_CTRL_CLEAR_EN
  // One extra bit so the terminal count COLS*ROWS is representable even for a full 2^ADDR_W map.
  localparam int              FILL_W = ADDR_W + 1;
  localparam logic [FILL_W-1:0] CELLS = FILL_W'(COLS * ROWS);
  logic [FILL_W-1:0] fill_q, fill_d;
`endif

  function automatic logic [6:0] row_inc(input logic [6:0] r);
    return (r == LAST_ROW) ? 7'd0 : r + 7'd1;
  endfunction

  function automatic logic [6:0] clamp7(input logic [6:0] v, input logic [6:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign accept   = cmd_valid && ready_q;
  assign cur_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef TEXT_CTRL_CLEAR_EN
    fill_d    = fill_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op_e'(cmd_op))
            OP_PUTC: begin
              wr_en_d   = 1'b1;
              wr_addr_d = cur_addr;
              wr_data_d = cmd_data[7:0];
              if (col_q == LAST_COL) begin
                col_d = 7'd0;
                row_d = row_inc(row_q);
              end else begin
                col_d = col_q + 7'd1;
              end
            end
            OP_SETPOS: begin
              col_d = clamp7(cmd_data[6:0], LAST_COL);
              row_d = clamp7(cmd_data[13:7], LAST_ROW);
            end
            OP_NEWLINE: begin
              col_d = 7'd0;
              row_d = row_inc(row_q);
            end
            OP_CLEAR: begin
`ifdef TEXT_CTRL_CLEAR_EN
              state_d = CLEAR;
              fill_d  = '0;
`else
              col_d = 7'd0;
              row_d = 7'd0;
`endif
            end
          endcase
        end
      end

      CLEAR: begin
`ifdef TEXT_CTRL_CLEAR_EN
        // The terminal count is reached one cycle after the last write, so wr_en drops with busy.
        if (fill_q == CELLS) begin
          state_d = IDLE;
          col_d   = 7'd0;
          row_d   = 7'd0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = fill_q[ADDR_W-1:0];
          wr_data_d = 8'h20;
          fill_d    = fill_q + 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

`ifdef TEXT_CTRL_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end
`endif

  assign cmd_ready  = ready_q;
  assign busy       = busy_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule
